// File: rtl/gsim_fwd.sv
`default_nettype none
// ============================================================================
// Module : gsim_fwd  -- streamed forward band product b = A*x (inverse of GSIM)
//          Optional macro GSIM_FWD_SAT16_EN adds the rounded, saturated b_int.
// Rev    : 1.0  initial release
// ============================================================================
module gsim_fwd #(
    parameter int N    = 16,
    parameter int DW   = 32,
    parameter int FRAC = 16,
    parameter int OW   = DW + 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    input  logic [DW-1:0] x_in,
    output logic          in_ready,
    output logic          out_valid,
    output logic [OW-1:0] b_out,
    output logic          done
`ifdef GSIM_FWD_SAT16_EN
    ,
    output logic [15:0]   b_int
`endif
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_in_cnt, w_in_cnt_nxt;
    logic [1:0]           r_flush_cnt, w_flush_cnt_nxt;
    logic signed [DW-1:0] r_win [7];
    logic signed [DW-1:0] w_win_nxt [7];
    logic signed [DW-1:0] w_new;
    logic                 w_accept, w_shift, w_clear_hist, w_emit, w_done_nxt;
    logic                 r_out_valid, r_done;
    logic signed [OW-1:0] r_b_out;
    logic signed [OW-1:0] w_e [7];
    logic signed [OW-1:0] w_p1, w_p2, w_p3, w_sum;

    assign in_ready  = (r_state != S_FLUSH) || !reset;
    assign w_accept  = in_en && in_ready;
    assign out_valid = r_out_valid;
    assign done      = r_done;
    assign b_out     = r_b_out;

    always_comb begin
        w_state_nxt     = r_state;
        w_in_cnt_nxt    = r_in_cnt;
        w_flush_cnt_nxt = r_flush_cnt;
        w_shift         = 1'b0;
        w_clear_hist    = 1'b0;
        w_emit          = 1'b0;
        w_done_nxt      = 1'b0;
        w_new           = $signed(x_in);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shift      = 1'b1;
                    w_clear_hist = 1'b1;
                    w_in_cnt_nxt = CW'(1);
                    w_state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    w_shift      = 1'b1;
                    w_emit       = (r_in_cnt >= CW'(3));
                    w_in_cnt_nxt = r_in_cnt + CW'(1);
                    if (r_in_cnt == CW'(N - 1)) begin
                        w_state_nxt     = S_FLUSH;
                        w_flush_cnt_nxt = 2'd0;
                    end
                end
            end
            S_FLUSH: begin
                // Zero-fill the trailing edge so the last three rows see x[N..N+2] = 0.
                w_shift         = 1'b1;
                w_new           = '0;
                w_emit          = 1'b1;
                w_flush_cnt_nxt = r_flush_cnt + 2'd1;
                if (r_flush_cnt == 2'd2) begin
                    w_done_nxt      = 1'b1;
                    w_state_nxt     = S_IDLE;
                    w_in_cnt_nxt    = '0;
                    w_flush_cnt_nxt = 2'd0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Window after this cycle's shift: [0] is the newest sample, [3] the row centre.
    always_comb begin
        for (int k = 0; k < 7; k++) begin
            w_win_nxt[k] = r_win[k];
        end
        if (w_shift) begin
            w_win_nxt[0] = w_new;
            for (int k = 1; k < 7; k++) begin
                w_win_nxt[k] = w_clear_hist ? '0 : r_win[k-1];
            end
        end
        for (int k = 0; k < 7; k++) begin
            w_e[k] = {{(OW-DW){w_win_nxt[k][DW-1]}}, w_win_nxt[k]};
        end
    end

    // Symmetric band: pair equal-coefficient taps, then shift-add constants 20, 13, 6.
    assign w_p1  = w_e[2] + w_e[4];
    assign w_p2  = w_e[1] + w_e[5];
    assign w_p3  = w_e[0] + w_e[6];
    assign w_sum = (w_e[3] <<< 4) + (w_e[3] <<< 2)
                 - ((w_p1 <<< 3) + (w_p1 <<< 2) + w_p1)
                 + (w_p2 <<< 2) + (w_p2 <<< 1)
                 - w_p3;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_in_cnt    <= '0;
            r_flush_cnt <= 2'd0;
            for (int k = 0; k < 7; k++) begin
                r_win[k] <= '0;
            end
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_b_out     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_cnt    <= w_in_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            for (int k = 0; k < 7; k++) begin
                r_win[k] <= w_win_nxt[k];
            end
            r_out_valid <= w_emit;
            r_done      <= w_done_nxt;
            if (w_emit) begin
                r_b_out <= w_sum;
            end
        end
    end

`ifdef GSIM_FWD_SAT16_EN
    localparam logic [OW-1:0]        c_half = OW'(1) << (FRAC - 1);
    localparam logic signed [OW-1:0] c_smax = OW'(32767);
    localparam logic signed [OW-1:0] c_smin = -(OW'(32768));

    logic                 w_neg;
    logic [OW-1:0]        w_mag, w_rnd_mag;
    logic signed [OW-1:0] w_rnd;

    // Round the magnitude so ties go away from zero for both signs.
    always_comb begin
        w_neg     = r_b_out[OW-1];
        w_mag     = w_neg ? -r_b_out : r_b_out;
        w_rnd_mag = (w_mag + c_half) >> FRAC;
        w_rnd     = w_neg ? -w_rnd_mag : w_rnd_mag;
        if (w_rnd > c_smax) begin
            b_int = 16'h7FFF;
        end else if (w_rnd < c_smin) begin
            b_int = 16'h8000;
        end else begin
            b_int = w_rnd[15:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gsim_fwd.sv
`default_nettype none
// ============================================================================
// Module : tb_gsim_fwd  -- self-checking bench for gsim_fwd (table + random)
// Rev    : 1.0  initial release
// ============================================================================
module tb_gsim_fwd;
    localparam int N    = 16;
    localparam int DW   = 32;
    localparam int FRAC = 16;
    localparam int OW   = DW + 6;

    typedef logic [N-1:0][DW-1:0] xvec_t;
    typedef logic [N-1:0][63:0]   bvec_t;
    typedef struct packed {
        xvec_t x;
        bvec_t exp;
    } vec_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          in_en = 1'b0;
    logic [DW-1:0] x_in  = '0;
    logic          in_ready, out_valid, done;
    logic [OW-1:0] b_out;
`ifdef GSIM_FWD_SAT16_EN
    logic [15:0]   b_int;
`endif

    gsim_fwd #(.N(N), .DW(DW), .FRAC(FRAC), .OW(OW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_en    (in_en),
        .x_in     (x_in),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .b_out    (b_out),
        .done     (done)
`ifdef GSIM_FWD_SAT16_EN
        ,
        .b_int    (b_int)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int done_cnt = 0;
    logic signed [63:0] cap_b [$];
    bit                 cap_done [$];
    int                 cap_cyc [$];
    int                 cap_bi [$];
    int                 acc_cyc [N];

    int pat [N] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
    int imp [N] = '{0, 0, -1, 6, -13, 20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0};
    vec_t tbl [3];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        logic signed [63:0] v;
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1) done_cnt++;
        if (out_valid === 1'b1) begin
            v = $signed(b_out);
            cap_b.push_back(v);
            cap_done.push_back(done === 1'b1);
            cap_cyc.push_back(cyc);
`ifdef GSIM_FWD_SAT16_EN
            cap_bi.push_back(int'($signed(b_int)));
`endif
        end
    endtask

    // Reference: b[j] = sum_k c[|k|] * x[j+k], x outside 0..N-1 taken as zero.
    function automatic bvec_t model(input xvec_t xv);
        int     c [4] = '{20, -13, 6, -1};
        longint s;
        bvec_t  r;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = -3; k <= 3; k++) begin
                if (j + k >= 0 && j + k < N)
                    s += longint'(c[k < 0 ? -k : k]) * longint'($signed(xv[j+k]));
            end
            r[j] = s;
        end
        return r;
    endfunction

    function automatic int round_sat(input longint b);
        longint m, r;
        m = (b < 0) ? -b : b;
        r = (m + (longint'(1) << (FRAC - 1))) / (longint'(1) << FRAC);
        r = (b < 0) ? -r : r;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic run_frame(input xvec_t xv, input int gap, input bit rnd_gap);
        int g;
        cap_b.delete(); cap_done.delete(); cap_cyc.delete(); cap_bi.delete();
        done_cnt = 0;
        for (int i = 0; i < N; i++) begin
            in_en = 1'b1;
            x_in  = xv[i];
            tick();
            acc_cyc[i] = cyc;
            in_en = 1'b0;
            x_in  = $urandom;
            if (i < N - 1) begin
                g = rnd_gap ? int'($urandom_range(0, 3)) : gap;
                repeat (g) tick();
            end
        end
        in_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            chk("in_ready_flush", in_ready, 0);
            tick();
        end
        in_en = 1'b0;
        chk("in_ready_after_flush", in_ready, 1);
    endtask

    task automatic check_frame(input bvec_t exp, input string nm);
        int lat;
        chk({nm, "_count"}, cap_b.size(), N);
        chk({nm, "_done_cnt"}, done_cnt, 1);
        for (int j = 0; j < N && j < cap_b.size(); j++) begin
            chk($sformatf("%s_b%0d", nm, j), cap_b[j], $signed(exp[j]));
            chk($sformatf("%s_done%0d", nm, j), cap_done[j], (j == N - 1));
            lat = (j <= N - 4) ? acc_cyc[j+3] : acc_cyc[N-1] + j - (N - 4);
            chk($sformatf("%s_cyc%0d", nm, j), cap_cyc[j], lat);
`ifdef GSIM_FWD_SAT16_EN
            if (j < cap_bi.size())
                chk($sformatf("%s_bint%0d", nm, j), cap_bi[j], round_sat($signed(exp[j])));
`endif
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        xvec_t xv;
        bvec_t ex;
        logic signed [63:0] last_b;

        for (int i = 0; i < N; i++) begin
            tbl[0].x[i]   = 32'h0001_0000;
            tbl[0].exp[i] = longint'(pat[i]) * 65536;
            tbl[1].x[i]   = 32'hFFFF_8000;
            tbl[1].exp[i] = longint'(pat[i]) * -32768;
            tbl[2].x[i]   = (i == 5) ? 32'h0001_0000 : 32'h0;
            tbl[2].exp[i] = longint'(imp[i]) * 65536;
        end

        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_b_out", $signed(b_out), 0);
        reset = 1'b1;
        tick();

        // Ones, then -0.5 starting at T+4, then impulse: all back-to-back
        for (int k = 0; k < 3; k++) begin
            run_frame(tbl[k].x, 0, 1'b0);
            check_frame(tbl[k].exp, $sformatf("tbl%0d", k));
        end

        // Impulse with two idle cycles after every accept
        repeat (2) tick();
        run_frame(tbl[2].x, 2, 1'b0);
        check_frame(tbl[2].exp, "gap2");

        // Reset mid-frame at in_cnt = 9
        repeat (2) tick();
        for (int i = 0; i < 9; i++) begin
            in_en = 1'b1;
            x_in  = 32'h0001_0000;
            tick();
        end
        in_en = 1'b0;
        cap_b.delete();
        done_cnt = 0;
        reset = 1'b0;
        in_en = 1'b1;
        tick();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_b_out", $signed(b_out), 0);
        chk("midrst_in_ready", in_ready, 1);
        reset = 1'b1;
        in_en = 1'b0;
        repeat (5) tick();
        chk("midrst_no_output", cap_b.size(), 0);
        chk("midrst_no_done", done_cnt, 0);
        run_frame(tbl[0].x, 0, 1'b0);
        check_frame(tbl[0].exp, "post_rst");

        // Random frames (plus extreme-value frames) against the reference model
        last_b = 0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                case (r)
                    0: xv[i] = 32'h8000_0000;
                    1: xv[i] = 32'h7FFF_FFFF;
                    2: xv[i] = (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                    default: xv[i] = $urandom;
                endcase
            end
            ex = model(xv);
            run_frame(xv, 0, (r >= 3));
            check_frame(ex, $sformatf("rnd%0d", r));
            last_b = $signed(ex[N-1]);
        end
        repeat (3) tick();
        chk("hold_b_out", $signed(b_out), last_b);
        chk("hold_out_valid", out_valid, 0);

`ifdef GSIM_FWD_SAT16_EN
        for (int i = 0; i < N; i++) xv[i] = 32'h7FFF_0000;
        run_frame(xv, 0, 1'b0);
        check_frame(model(xv), "sat");
        for (int j = 0; j < N && j < cap_bi.size(); j++)
            chk($sformatf("sat_tbl%0d", j), cap_bi[j], (j == 1 || j == N - 2) ? -32767 : 32767);

        for (int i = 0; i < N; i++) xv[i] = (i == 5) ? 32'h0001_8000 : 32'h0;
        run_frame(xv, 0, 1'b0);
        check_frame(model(xv), "imp15");
        if (cap_bi.size() > 5) chk("imp15_centre", cap_bi[5], 30);
        else chk("imp15_centre_missing", cap_bi.size(), 6);

        for (int i = 0; i < N; i++) xv[i] = (i == 5) ? 32'h0000_8000 : 32'h0;
        run_frame(xv, 0, 1'b0);
        check_frame(model(xv), "imp05");
        if (cap_bi.size() > 4) chk("imp05_b4", cap_bi[4], -7);
        else chk("imp05_b4_missing", cap_bi.size(), 5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
